// File: rtl/dsp_loader_pkg.sv
// Shared types and header field layout for the DSP memory loader.
package dsp_loader_pkg;

  typedef enum logic [1:0] {HDR, LEN, DATA, DROP} state_t;

  localparam int HDR_PROC_LSB = 24;
  localparam int HDR_PROC_W   = 8;
  localparam int HDR_MEM_LSB  = 20;
  localparam int HDR_MEM_W    = 4;

  localparam logic [HDR_MEM_W-1:0] MEM_CMD  = 4'd0;
  localparam logic [HDR_MEM_W-1:0] MEM_ENV  = 4'd1;
  localparam logic [HDR_MEM_W-1:0] MEM_FREQ = 4'd2;

endpackage

// File: rtl/dsp_wen_decode.sv
// One-hot write-enable decode: bit proc*NMEM+mem is set when en is high.
module dsp_wen_decode
  import dsp_loader_pkg::*;
#(
  parameter int NPROC = 4,
  parameter int NMEM  = 3
) (
  input  logic [HDR_PROC_W-1:0]  proc,
  input  logic [HDR_MEM_W-1:0]   mem,
  input  logic                   en,
  output logic [NPROC*NMEM-1:0]  wen
);

  always_comb begin
    wen = '0;
    for (int p = 0; p < NPROC; p++) begin
      for (int m = 0; m < NMEM; m++) begin
        wen[p*NMEM+m] = en && (proc == HDR_PROC_W'(p)) && (mem == HDR_MEM_W'(m));
      end
    end
  end

endmodule

// File: rtl/dsp_mem_loader.sv
// Framed stream-to-memory write router: header, length, then auto-incrementing payload.
//   state | meaning
//   HDR   | waiting for header word (proc, mem, base)
//   LEN   | waiting for length word, validates target
//   DATA  | payload words written to base+count
//   DROP  | discarding rest of a bad frame until s_last
module dsp_mem_loader
  import dsp_loader_pkg::*;
#(
  parameter int NPROC     = 4,
  parameter int NMEM      = 3,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16,
  parameter int LENWIDTH  = 17
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATAWIDTH-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [DATAWIDTH-1:0]   mem_write_data,
  output logic [ADDRWIDTH-1:0]   mem_write_addr,
  output logic [NPROC*NMEM-1:0]  mem_wen,
  output logic                   done,
  output logic                   err,
  input  logic                   err_clr,
  output logic [LENWIDTH-1:0]    words_written
);

  state_t                 state, state_n;
  logic [HDR_PROC_W-1:0]  proc_q, proc_n;
  logic [HDR_MEM_W-1:0]   mem_q, mem_n;
  logic [ADDRWIDTH-1:0]   base_q, base_n;
  logic [LENWIDTH-1:0]    len_q, len_n, len_in;
  logic [LENWIDTH-1:0]    cnt_q, cnt_n, cnt_inc;
  logic [DATAWIDTH-1:0]   wdata_n;
  logic [ADDRWIDTH-1:0]   waddr_n;
  logic [LENWIDTH-1:0]    ww_n;
  logic                   wen_en, done_n, err_set, err_n, beat, bad_target;
  logic [NPROC*NMEM-1:0]  wen_next;

  assign beat       = s_valid && s_ready;
  assign len_in     = s_data[LENWIDTH-1:0];
  assign cnt_inc    = cnt_q + 1'b1;
  assign bad_target = (32'(proc_q) >= NPROC) || (32'(mem_q) >= NMEM);

  always_comb begin
    state_n = state;
    proc_n  = proc_q;
    mem_n   = mem_q;
    base_n  = base_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    wdata_n = mem_write_data;
    waddr_n = mem_write_addr;
    ww_n    = words_written;
    wen_en  = 1'b0;
    done_n  = 1'b0;
    err_set = 1'b0;
    case (state)
      HDR: if (beat) begin
        proc_n = s_data[HDR_PROC_LSB +: HDR_PROC_W];
        mem_n  = s_data[HDR_MEM_LSB +: HDR_MEM_W];
        base_n = s_data[ADDRWIDTH-1:0];
        if (s_last) err_set = 1'b1;
        else        state_n = LEN;
      end
      LEN: if (beat) begin
        len_n = len_in;
        cnt_n = '0;
        if (bad_target) begin
          err_set = 1'b1;
          state_n = s_last ? HDR : DROP;
        end else if (len_in == '0) begin
          if (s_last) begin
            done_n  = 1'b1;
            ww_n    = '0;
            state_n = HDR;
          end else begin
            err_set = 1'b1;
            state_n = DROP;
          end
        end else if (s_last) begin
          err_set = 1'b1;
          state_n = HDR;
        end else begin
          state_n = DATA;
        end
      end
      DATA: if (beat) begin
        wen_en  = 1'b1;
        wdata_n = s_data;
        waddr_n = base_q + cnt_q[ADDRWIDTH-1:0];
        cnt_n   = cnt_inc;
        if (cnt_inc == len_q) begin
          ww_n = len_q;
          if (s_last) begin
            done_n  = 1'b1;
            state_n = HDR;
          end else begin
            err_set = 1'b1;
            state_n = DROP;
          end
        end else if (s_last) begin
          // early abort: the word is still written, frame ends without done
          err_set = 1'b1;
          ww_n    = cnt_inc;
          state_n = HDR;
        end
      end
      DROP: if (beat && s_last) state_n = HDR;
      default: state_n = HDR;
    endcase
    err_n = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  dsp_wen_decode #(.NPROC(NPROC), .NMEM(NMEM)) u_wen_decode (
    .proc (proc_q),
    .mem  (mem_q),
    .en   (wen_en),
    .wen  (wen_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= HDR;
      s_ready        <= 1'b0;
      proc_q         <= '0;
      mem_q          <= '0;
      base_q         <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      mem_write_data <= '0;
      mem_write_addr <= '0;
      mem_wen        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      words_written  <= '0;
    end else begin
      state          <= state_n;
      s_ready        <= 1'b1;
      proc_q         <= proc_n;
      mem_q          <= mem_n;
      base_q         <= base_n;
      len_q          <= len_n;
      cnt_q          <= cnt_n;
      mem_write_data <= wdata_n;
      mem_write_addr <= waddr_n;
      mem_wen        <= wen_next;
      done           <= done_n;
      err            <= err_n;
      words_written  <= ww_n;
    end
  end

endmodule

// File: tb/tb_dsp_mem_loader.sv
// Scoreboard bench for dsp_mem_loader: stimulus pushes expected writes, a monitor pops and compares.
module tb_dsp_mem_loader;

  localparam int NPROC = 4;
  localparam int NMEM  = 3;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int LW    = 17;
  localparam int NW    = NPROC * NMEM;

  typedef struct {
    logic [NW-1:0] wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    logic          chk_ad;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] mem_write_data;
  logic [AW-1:0] mem_write_addr;
  logic [NW-1:0] mem_wen;
  logic          done;
  logic          err;
  logic          err_clr = 1'b0;
  logic [LW-1:0] words_written;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dsp_mem_loader #(
    .NPROC(NPROC), .NMEM(NMEM), .DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mem_write_data (mem_write_data),
    .mem_write_addr (mem_write_addr),
    .mem_wen        (mem_wen),
    .done           (done),
    .err            (err),
    .err_clr        (err_clr),
    .words_written  (words_written)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input int p, input int m, input int b);
    return {8'(p), 4'(m), 4'h0, 16'(b)};
  endfunction

  task automatic push(input int bit_i, input int a, input logic [DW-1:0] d, input logic dn);
    exp_t e;
    e.wen    = NW'(1) << bit_i;
    e.addr   = AW'(a);
    e.data   = d;
    e.done   = dn;
    e.chk_ad = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_done_only();
    exp_t e;
    e.wen    = '0;
    e.addr   = '0;
    e.data   = '0;
    e.done   = 1'b1;
    e.chk_ad = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!s_ready && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 64'(s_ready), 64'd1);
  endtask

  // Monitor: any write or done cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (mem_wen != '0 || done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: wen=%0h addr=%0h data=%0h done=%0b, none expected",
                 mem_wen, mem_write_addr, mem_write_data, done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_chk++;
        if (mem_wen !== e.wen || done !== e.done ||
            (e.chk_ad && (mem_write_addr !== e.addr || mem_write_data !== e.data))) begin
          n_fail++;
          $display("FAIL write: got wen=%0h addr=%0h data=%0h done=%0b expected wen=%0h addr=%0h data=%0h done=%0b",
                   mem_wen, mem_write_addr, mem_write_data, done, e.wen, e.addr, e.data, e.done);
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_outputs", {mem_wen, done, err, words_written}, 64'd0);
    check("rst_wdata_waddr", {mem_write_data, mem_write_addr}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("ready_after_release", 64'(s_ready), 64'd0);
    wait_ready("ready_up");

    // basic frame: proc 2, mem 1 -> wen bit 7
    push(7, 'h10, 32'hA, 1'b0);
    push(7, 'h11, 32'hB, 1'b0);
    push(7, 'h12, 32'hC, 1'b1);
    beat(hdr(2, 1, 'h10), 1'b0);
    beat(32'd3, 1'b0);
    beat(32'hA, 1'b0);
    beat(32'hB, 1'b0);
    beat(32'hC, 1'b1);
    drain("t1_drain");
    check("t1_ww", 64'(words_written), 64'd3);
    check("t1_err", 64'(err), 64'd0);

    // address wrap
    push(2, 'hFFFF, 32'h1111_0001, 1'b0);
    push(2, 'h0000, 32'h1111_0002, 1'b1);
    beat(hdr(0, 2, 'hFFFF), 1'b0);
    beat(32'd2, 1'b0);
    beat(32'h1111_0001, 1'b0);
    beat(32'h1111_0002, 1'b1);
    drain("t2_drain");
    check("t2_ww", 64'(words_written), 64'd2);
    check("t2_err", 64'(err), 64'd0);

    // out-of-range proc is dropped, then a good frame still works
    beat(hdr(4, 0, 'h0), 1'b0);
    beat(32'd2, 1'b0);
    beat(32'hDEAD_0001, 1'b0);
    beat(32'hDEAD_0002, 1'b1);
    drain("t3_drop_drain");
    check("t3_err_set", 64'(err), 64'd1);
    push(11, 'h100, 32'hD00D, 1'b1);
    beat(hdr(3, 2, 'h100), 1'b0);
    beat(32'd1, 1'b0);
    beat(32'hD00D, 1'b1);
    drain("t3_good_drain");
    check("t3_err_sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t3_err_clr", 64'(err), 64'd0);

    // early abort on second of four words
    push(3, 'h20, 32'h5000_0000, 1'b0);
    push(3, 'h21, 32'h5000_0001, 1'b0);
    beat(hdr(1, 0, 'h20), 1'b0);
    beat(32'd4, 1'b0);
    beat(32'h5000_0000, 1'b0);
    beat(32'h5000_0001, 1'b1);
    drain("t4_drain");
    check("t4_err", 64'(err), 64'd1);
    check("t4_ww", 64'(words_written), 64'd2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    push(0, 'h5, 32'h7777, 1'b1);
    beat(hdr(0, 0, 'h5), 1'b0);
    beat(32'd1, 1'b0);
    beat(32'h7777, 1'b1);
    drain("t4_next_drain");
    check("t4_next_ww", 64'(words_written), 64'd1);
    check("t4_next_err", 64'(err), 64'd0);

    // zero-length frame
    push_done_only();
    beat(hdr(1, 1, 'h0), 1'b0);
    beat(32'd0, 1'b1);
    drain("t5_len0_drain");
    check("t5_len0_ww", 64'(words_written), 64'd0);
    check("t5_len0_err", 64'(err), 64'd0);

    // gapped valid: writes follow the gaps, addresses contiguous
    beat(hdr(3, 0, 'h40), 1'b0);
    beat(32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(9, 'h40 + i, 32'hC0DE_0000 + 32'(i), i == 3);
      beat(32'hC0DE_0000 + 32'(i), i == 3);
      if (i != 3) idle(1);
    end
    drain("t5_gap_drain");
    check("t5_gap_ww", 64'(words_written), 64'd4);

    // reset mid-frame
    push(8, 'h200, 32'hBEEF_0000, 1'b0);
    push(8, 'h201, 32'hBEEF_0001, 1'b0);
    beat(hdr(2, 2, 'h200), 1'b0);
    beat(32'd5, 1'b0);
    beat(32'hBEEF_0000, 1'b0);
    beat(32'hBEEF_0001, 1'b0);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("t6_rst_outputs", {mem_wen, done, err, words_written}, 64'd0);
    check("t6_rst_wdata_waddr", {mem_write_data, mem_write_addr}, 64'd0);
    check("t6_rst_ready", 64'(s_ready), 64'd0);
    idle(2);
    resetn = 1'b1;
    wait_ready("t6_ready_up");
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    push(5, 'h300, 32'hF00D_0000, 1'b0);
    push(5, 'h301, 32'hF00D_0001, 1'b1);
    beat(hdr(1, 2, 'h300), 1'b0);
    beat(32'd2, 1'b0);
    beat(32'hF00D_0000, 1'b0);
    beat(32'hF00D_0001, 1'b1);
    drain("t6_drain");
    check("t6_ww", 64'(words_written), 64'd2);
    check("t6_err", 64'(err), 64'd0);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
